// File: rtl/idma_seq_pkg.sv
// rtl/idma_seq_pkg.sv - shared types, widths and beat math for the 1D dp sequencer
package idma_seq_pkg;

  localparam int unsigned DataWidth        = 32;
  localparam int unsigned AddrWidth        = 32;
  localparam int unsigned LenWidth         = 16;
  localparam int unsigned NumAxInFlightDef = 2;
  localparam int unsigned StrbWidth        = DataWidth / 8;
  localparam int unsigned OffW             = $clog2(StrbWidth);
  localparam int unsigned BeatW            = LenWidth + 1;

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [LenWidth-1:0]  len_t;
  typedef logic [OffW-1:0]      off_t;
  typedef logic [BeatW-1:0]     beat_t;

  typedef struct packed {
    addr_t src_addr;
    addr_t dst_addr;
    len_t  length;
  } idma_seq_req_t;

  typedef struct packed {
    off_t offset;
    off_t tailer;
    off_t shift;
  } r_dp_req_t;

  typedef struct packed {
    off_t offset;
    off_t tailer;
    off_t shift;
  } w_dp_req_t;

  typedef struct packed {
    logic error;
  } r_dp_rsp_t;

  typedef struct packed {
    logic error;
  } w_dp_rsp_t;

  typedef struct packed {
    addr_t addr;
  } read_meta_channel_t;

  typedef struct packed {
    addr_t addr;
  } write_meta_channel_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_DRAIN,
    SEQ_RESP
  } seq_state_e;

  // Number of bus words touched by len bytes starting at byte offset off.
  function automatic beat_t beat_count(input off_t off, input len_t len);
    logic [LenWidth+1:0] total;
    total = {{(LenWidth+2-OffW){1'b0}}, off} + {2'b00, len} + (LenWidth+2)'(StrbWidth - 1);
    return beat_t'(total >> OffW);
  endfunction

  // Unused bytes at the top of the last word.
  function automatic off_t tail_bytes(input off_t off, input len_t len);
    return off_t'(off_t'(0) - (off + len[OffW-1:0]));
  endfunction

endpackage

// File: rtl/idma_seq_beat_gen.sv
// rtl/idma_seq_beat_gen.sv - per-side beat counter, offset/tailer and meta+dp channel fork
import idma_seq_pkg::*;

module idma_seq_beat_gen #(
  parameter int unsigned InFlightLimit = 0
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  start_i,
  input  addr_t addr_i,
  input  len_t  len_i,
  input  off_t  shift_i,
  input  logic  active_i,
  output addr_t meta_addr_o,
  output logic  meta_valid_o,
  input  logic  meta_ready_i,
  output off_t  offset_o,
  output off_t  tailer_o,
  output off_t  shift_o,
  output logic  dp_valid_o,
  input  logic  dp_ready_i,
  input  logic  rsp_fire_i,
  output logic  issued_o,
  output logic  done_o
);

  addr_t base_q;
  off_t  off_q, tail_q, shift_q;
  beat_t nbeats_q, idx_q, pend_q;
  logic  meta_sent_q, dp_sent_q;
  logic  beat_left, may_issue, meta_fire, dp_fire, meta_done, dp_done;

  assign beat_left = (idx_q != nbeats_q);

  // A beat whose dp request already went out must still be allowed to finish its meta.
  if (InFlightLimit == 0) begin : g_unlimited
    assign may_issue = 1'b1;
  end else begin : g_limited
    assign may_issue = dp_sent_q || (pend_q < beat_t'(InFlightLimit));
  end

  assign meta_valid_o = active_i && beat_left && may_issue && !meta_sent_q;
  assign dp_valid_o   = active_i && beat_left && may_issue && !dp_sent_q;
  assign meta_fire    = meta_valid_o && meta_ready_i;
  assign dp_fire      = dp_valid_o && dp_ready_i;
  assign meta_done    = meta_sent_q || meta_fire;
  assign dp_done      = dp_sent_q || dp_fire;

  assign meta_addr_o = base_q + (addr_t'(idx_q) << OffW);
  assign offset_o    = (idx_q == '0) ? off_q : '0;
  assign tailer_o    = (idx_q == nbeats_q - beat_t'(1)) ? tail_q : '0;
  assign shift_o     = shift_q;
  assign issued_o    = !beat_left;
  assign done_o      = !beat_left && (pend_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q      <= '0;
      off_q       <= '0;
      tail_q      <= '0;
      shift_q     <= '0;
      nbeats_q    <= '0;
      idx_q       <= '0;
      pend_q      <= '0;
      meta_sent_q <= 1'b0;
      dp_sent_q   <= 1'b0;
    end else if (start_i) begin
      base_q      <= {addr_i[AddrWidth-1:OffW], {OffW{1'b0}}};
      off_q       <= addr_i[OffW-1:0];
      tail_q      <= tail_bytes(addr_i[OffW-1:0], len_i);
      shift_q     <= shift_i;
      nbeats_q    <= beat_count(addr_i[OffW-1:0], len_i);
      idx_q       <= '0;
      pend_q      <= '0;
      meta_sent_q <= 1'b0;
      dp_sent_q   <= 1'b0;
    end else begin
      if (meta_done && dp_done) begin
        idx_q       <= idx_q + beat_t'(1);
        meta_sent_q <= 1'b0;
        dp_sent_q   <= 1'b0;
      end else begin
        meta_sent_q <= meta_done;
        dp_sent_q   <= dp_done;
      end
      case ({dp_fire, rsp_fire_i})
        2'b10:   pend_q <= pend_q + beat_t'(1);
        2'b01:   pend_q <= pend_q - beat_t'(1);
        default: pend_q <= pend_q;
      endcase
    end
  end

endmodule

// File: rtl/idma_txrx_obi_dp_sequencer.sv
// rtl/idma_txrx_obi_dp_sequencer.sv - sequences one 1D transfer into read/write beat requests
import idma_seq_pkg::*;

module idma_txrx_obi_dp_sequencer #(
  parameter int unsigned NumAxInFlight = NumAxInFlightDef
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  idma_seq_req_t       req_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  output logic                rsp_o,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output read_meta_channel_t  ar_req_o,
  output logic                ar_valid_o,
  input  logic                ar_ready_i,
  output r_dp_req_t           r_dp_req_o,
  output logic                r_dp_valid_o,
  input  logic                r_dp_ready_i,
  input  r_dp_rsp_t           r_dp_rsp_i,
  input  logic                r_dp_valid_i,
  output logic                r_dp_ready_o,
  output write_meta_channel_t aw_req_o,
  output logic                aw_valid_o,
  input  logic                aw_ready_i,
  output w_dp_req_t           w_dp_req_o,
  output logic                w_dp_valid_o,
  input  logic                w_dp_ready_i,
  input  w_dp_rsp_t           w_dp_rsp_i,
  input  logic                w_dp_valid_i,
  output logic                w_dp_ready_o,
  output logic                busy_o
);

  seq_state_e state_q, state_d;
  logic       alive_q, err_q, accept, dp_rsp_ready;
  logic       r_rsp_fire, w_rsp_fire;
  logic       rd_issued, rd_done, wr_issued, wr_done;
  off_t       shift;

  assign accept     = req_valid_i && req_ready_o;
  assign shift      = off_t'(req_i.src_addr[OffW-1:0] - req_i.dst_addr[OffW-1:0]);
  assign r_rsp_fire = r_dp_valid_i && r_dp_ready_o;
  assign w_rsp_fire = w_dp_valid_i && w_dp_ready_o;

  always_comb begin
    state_d      = state_q;
    req_ready_o  = 1'b0;
    rsp_valid_o  = 1'b0;
    rsp_o        = 1'b0;
    dp_rsp_ready = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        // alive_q keeps ready low for the first cycle after reset is released
        req_ready_o = alive_q;
        if (req_valid_i && alive_q) begin
          state_d = (req_i.length == '0) ? SEQ_RESP : SEQ_RUN;
        end
      end
      SEQ_RUN: begin
        dp_rsp_ready = 1'b1;
        if (rd_issued && wr_issued) state_d = SEQ_DRAIN;
      end
      SEQ_DRAIN: begin
        dp_rsp_ready = 1'b1;
        if (rd_done && wr_done) state_d = SEQ_RESP;
      end
      SEQ_RESP: begin
        rsp_valid_o = 1'b1;
        rsp_o       = err_q;
        if (rsp_ready_i) state_d = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  assign r_dp_ready_o = dp_rsp_ready;
  assign w_dp_ready_o = dp_rsp_ready;
  assign busy_o       = (state_q != SEQ_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SEQ_IDLE;
      alive_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
      if (accept) begin
        err_q <= 1'b0;
      end else if ((r_rsp_fire && r_dp_rsp_i.error) || (w_rsp_fire && w_dp_rsp_i.error)) begin
        err_q <= 1'b1;
      end
    end
  end

  idma_seq_beat_gen #(
    .InFlightLimit(0)
  ) i_read_gen (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (accept),
    .addr_i      (req_i.src_addr),
    .len_i       (req_i.length),
    .shift_i     (shift),
    .active_i    (state_q == SEQ_RUN),
    .meta_addr_o (ar_req_o.addr),
    .meta_valid_o(ar_valid_o),
    .meta_ready_i(ar_ready_i),
    .offset_o    (r_dp_req_o.offset),
    .tailer_o    (r_dp_req_o.tailer),
    .shift_o     (r_dp_req_o.shift),
    .dp_valid_o  (r_dp_valid_o),
    .dp_ready_i  (r_dp_ready_i),
    .rsp_fire_i  (r_rsp_fire),
    .issued_o    (rd_issued),
    .done_o      (rd_done)
  );

  idma_seq_beat_gen #(
    .InFlightLimit(NumAxInFlight)
  ) i_write_gen (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (accept),
    .addr_i      (req_i.dst_addr),
    .len_i       (req_i.length),
    .shift_i     (shift),
    .active_i    (state_q == SEQ_RUN),
    .meta_addr_o (aw_req_o.addr),
    .meta_valid_o(aw_valid_o),
    .meta_ready_i(aw_ready_i),
    .offset_o    (w_dp_req_o.offset),
    .tailer_o    (w_dp_req_o.tailer),
    .shift_o     (w_dp_req_o.shift),
    .dp_valid_o  (w_dp_valid_o),
    .dp_ready_i  (w_dp_ready_i),
    .rsp_fire_i  (w_rsp_fire),
    .issued_o    (wr_issued),
    .done_o      (wr_done)
  );

`ifndef SYNTHESIS
  a_r_rsp_legal: assert property (@(posedge clk_i) disable iff (!rst_ni) r_dp_valid_i |-> r_dp_ready_o);
  a_w_rsp_legal: assert property (@(posedge clk_i) disable iff (!rst_ni) w_dp_valid_i |-> w_dp_ready_o);
`endif

endmodule
